// File: rtl/instr_encoder_loader.sv
// Instruction encoder and program loader: packs symbolic MIPS instructions into
// 32-bit words and writes them to consecutive instruction-memory addresses.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready is high only in ACCEPT, and the source holds its fields while it waits.
module instr_encoder_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err_illegal,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [31:0]       word_q;
    logic              last_q;
    logic              full_q;
    logic              err_q;

    logic              enc_legal;
    logic [31:0]       enc_word;

    // Only the fields an operation uses are packed, so stray inputs never leak.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (in_op)
            4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
            4'd6:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
            4'd7:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
            4'd8:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
            4'd9:    enc_word = {6'b000010, in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_ACCEPT;
                        ptr_q   <= '0;
                        count_q <= '0;
                        full_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        if (enc_legal) begin
                            word_q  <= enc_word;
                            last_q  <= in_last;
                            state_q <= S_WRITE;
                        end else begin
                            err_q <= 1'b1;
                            if (in_last) begin
                                state_q <= S_DONE;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    count_q <= count_q + 1'b1;
                    // The pointer holds at the top address so it never wraps.
                    if (ptr_q == PTR_MAX) begin
                        full_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        ptr_q   <= ptr_q + 1'b1;
                        state_q <= last_q ? S_DONE : S_ACCEPT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_ACCEPT);
    assign imem_we     = (state_q == S_WRITE);
    assign imem_addr   = ptr_q;
    assign imem_wdata  = word_q;
    assign count       = count_q;
    assign done        = (state_q == S_DONE);
    assign full        = full_q;
    assign err_illegal = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed and randomized programs checked against
// an arithmetic model of the MIPS encodings; a second instance with ADDR_W=2 covers capacity.
module tb_instr_encoder_loader;

    localparam int W = 38;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic        rdy0, we0, done0, full0, err0;
    logic [5:0]  addr0;
    logic [31:0] wdata0;
    logic [6:0]  count0;
    logic [1:0]  st0;

    logic        rdy1, we1, done1, full1, err1;
    logic [1:0]  addr1;
    logic [31:0] wdata1;
    logic [2:0]  count1;
    logic [1:0]  st1;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs0_q[$];
    logic [W-1:0] obs1_q[$];

    instr_encoder_loader #(.ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy0),
        .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wdata0), .count(count0), .done(done0), .full(full0),
        .err_illegal(err0), .dbg_state_o(st0)
    );

    instr_encoder_loader #(.ADDR_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_last(in_last), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wdata1), .count(count1), .done(done1), .full(full1),
        .err_illegal(err1), .dbg_state_o(st1)
    );

    // clock / reset
    always #5 clk = ~clk;

    // write monitor: records every memory write as {addr, data}
    always @(negedge clk) begin
        if (we0) obs0_q.push_back({addr0, wdata0});
        if (we1) obs1_q.push_back({4'b0000, addr1, wdata1});
    end

    // reference model: {legal, word} from the encoding tables with plain arithmetic
    function automatic logic [32:0] model_encode(input int op, input int rs, input int rt,
                                                 input int rd, input int imm, input int tgt);
        longint w;
        bit     ok;
        ok = 1'b1;
        w  = 0;
        case (op)
            0: w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 32;
            1: w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 34;
            2: w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 36;
            3: w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 37;
            4: w = rs * 64'd2097152 + rt * 64'd65536 + rd * 64'd2048 + 42;
            5: w = 35 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            6: w = 43 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            7: w = 4 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            8: w = 8 * 64'd67108864 + rs * 64'd2097152 + rt * 64'd65536 + imm;
            9: w = 2 * 64'd67108864 + tgt;
            default: ok = 1'b0;
        endcase
        return {ok, w[31:0]};
    endfunction

    // driver tasks
    task automatic do_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        obs0_q.delete();
        obs1_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Holds the instruction until the selected instance shows ready; returns #1 after the handshake edge.
    task automatic send(input bit sel, input logic [3:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input bit last);
        bit acc;
        acc       = 1'b0;
        in_op     = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
        in_valid  = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if ((sel ? rdy1 : rdy0) === 1'b1) begin
                @(posedge clk);
                #1 acc = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL handshake_timeout: in_ready never rose for op %0d on instance %0d", op, sel);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", rdy0); end
        checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b want 0", we0); end
        checks++; if (addr0 !== 6'd0) begin errors++; $display("FAIL reset_imem_addr: got %0d want 0", addr0); end
        checks++; if (wdata0 !== 32'd0) begin errors++; $display("FAIL reset_imem_wdata: got %h want 0", wdata0); end
        checks++; if (count0 !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err_illegal: got %b want 0", err0); end
        checks++;
        if ({rdy1, we1, addr1, wdata1, count1, done1, full1, err1} !== '0) begin
            errors++;
            $display("FAIL reset_small_outputs: got nonzero outputs on small instance, want all 0");
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_add();
        do_reset();
        pulse_start();
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FFFFFF, 1'b0);
        @(negedge clk);
        checks++;
        if ({we0, addr0, wdata0} !== {1'b1, 6'd0, 32'h00221820}) begin
            errors++;
            $display("FAIL add_write: got we=%b addr=%0d data=%h want we=1 addr=0 data=00221820", we0, addr0, wdata0);
        end
        checks++; if (count0 !== 7'd0) begin errors++; $display("FAIL add_count_latency: got %0d want 0 during write", count0); end
        @(negedge clk);
        checks++; if (count0 !== 7'd1) begin errors++; $display("FAIL add_count: got %0d want 1", count0); end
        checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL add_single_pulse: got we=%b want 0", we0); end
    endtask

    task automatic test_program();
        do_reset();
        pulse_start();
        exp_q.push_back({6'd0, 32'h8C080004});
        exp_q.push_back({6'd1, 32'h00853022});
        exp_q.push_back({6'd2, 32'h08000010});
        send(1'b0, 4'd5, 5'd0, 5'd8, 5'd17, 16'd4, 26'h155, 1'b0);
        send(1'b0, 4'd1, 5'd4, 5'd5, 5'd6, 16'hFFFF, 26'h1, 1'b0);
        send(1'b0, 4'd9, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h10, 1'b1);
        repeat (2) @(negedge clk);
        checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL prog_write_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs0_q.size(); i++) begin
            checks++;
            if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL prog_write[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
        end
        checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL prog_done: got %b want 1", done0); end
        checks++; if (count0 !== 7'd3) begin errors++; $display("FAIL prog_count: got %0d want 3", count0); end
        checks++; if (full0 !== 1'b0) begin errors++; $display("FAIL prog_full: got %b want 0", full0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL prog_ready_in_done: got %b want 0", rdy0); end
        // restart from DONE loads from address 0 again
        @(posedge clk);
        #1;
        obs0_q.delete();
        pulse_start();
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (obs0_q.size() != 1 || obs0_q[0] !== {6'd0, 32'h00221820}) begin
            errors++;
            $display("FAIL restart_write: got %0d writes, first %h, want 1 write 0000221820", obs0_q.size(), obs0_q.size() > 0 ? obs0_q[0] : '0);
        end
        checks++; if (count0 !== 7'd1 || done0 !== 1'b1) begin errors++; $display("FAIL restart_state: got count=%0d done=%b want 1/1", count0, done0); end
    endtask

    task automatic test_unused_fields();
        do_reset();
        pulse_start();
        send(1'b0, 4'd7, 5'd1, 5'd2, 5'd31, 16'hFFFF, 26'h2AAAAAA, 1'b0);
        @(negedge clk);
        checks++; if (wdata0 !== 32'h1022FFFF) begin errors++; $display("FAIL beq_rd_ignored: got %h want 1022FFFF", wdata0); end
        @(posedge clk);
        #1;
        send(1'b0, 4'd8, 5'd3, 5'd9, 5'd31, 16'h8001, 26'h3FFFFFF, 1'b1);
        @(negedge clk);
        checks++;
        if (wdata0 !== 32'h20698001 || addr0 !== 6'd1) begin
            errors++;
            $display("FAIL addi_fields: got addr=%0d data=%h want addr=1 data=20698001", addr0, wdata0);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        pulse_start();
        send(1'b0, 4'd12, 5'd1, 5'd2, 5'd3, 16'd7, 26'd7, 1'b0);
        repeat (2) @(negedge clk);
        checks++; if (obs0_q.size() != 0) begin errors++; $display("FAIL illegal_no_write: got %0d writes want 0", obs0_q.size()); end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL illegal_err_set: got %b want 1", err0); end
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL illegal_stays_accept: got ready=%b want 1", rdy0); end
        @(posedge clk);
        #1;
        send(1'b0, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (obs0_q.size() != 1 || obs0_q[0] !== {6'd0, 32'h00221820}) begin
            errors++;
            $display("FAIL illegal_then_add: got %0d writes, want one 0000221820 at addr 0", obs0_q.size());
        end
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL illegal_err_sticky: got %b want 1", err0); end
        // illegal op carrying in_last ends the load on the next cycle
        @(posedge clk);
        #1;
        send(1'b0, 4'd15, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1);
        @(negedge clk);
        checks++; if (done0 !== 1'b1 || we0 !== 1'b0) begin errors++; $display("FAIL illegal_last_done: got done=%b we=%b want 1/0", done0, we0); end
        checks++; if (count0 !== 7'd1) begin errors++; $display("FAIL illegal_last_count: got %0d want 1", count0); end
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        checks++;
        if (err0 !== 1'b0 || count0 !== 7'd0 || rdy0 !== 1'b1) begin
            errors++;
            $display("FAIL restart_clears: got err=%b count=%0d ready=%b want 0/0/1", err0, count0, rdy0);
        end
    endtask

    task automatic test_capacity();
        logic [32:0] m;
        int op;
        do_reset();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            op = $urandom_range(0, 9);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            m = model_encode(op, int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm), int'(in_target));
            exp_q.push_back({6'(i), m[31:0]});
            send(1'b1, 4'(op), in_rs, in_rt, in_rd, in_imm, in_target, 1'b0);
        end
        // two more instructions offered; none may be taken
        for (int j = 0; j < 2; j++) begin
            in_op = 4'd0; in_valid = 1'b1; in_last = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c > 0) begin
                    checks++;
                    if (rdy1 !== 1'b0) begin errors++; $display("FAIL cap_ready_low: got %b want 0 (offer %0d)", rdy1, j + 5); end
                end
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        @(negedge clk);
        checks++; if (obs1_q.size() != 4) begin errors++; $display("FAIL cap_write_count: got %0d want 4", obs1_q.size()); end
        for (int i = 0; i < 4 && i < obs1_q.size(); i++) begin
            checks++;
            if (obs1_q[i] !== exp_q[i]) begin errors++; $display("FAIL cap_write[%0d]: got %h want %h", i, obs1_q[i], exp_q[i]); end
        end
        checks++;
        if (done1 !== 1'b1 || full1 !== 1'b1 || count1 !== 3'd4) begin
            errors++;
            $display("FAIL cap_state: got done=%b full=%b count=%0d want 1/1/4", done1, full1, count1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        pulse_start();
        in_op = 4'd1; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9; in_last = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL midflight_ready: got %b want 1", rdy0); end
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy0, we0, addr0, wdata0, count0, done0, full0, err0} !== '0) begin
            errors++;
            $display("FAIL midflight_outputs: got we=%b addr=%0d data=%h count=%0d done=%b want all 0", we0, addr0, wdata0, count0, done0);
        end
        checks++; if (obs0_q.size() != 0) begin errors++; $display("FAIL midflight_no_write: got %0d writes want 0", obs0_q.size()); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send(1'b0, 4'd3, 5'd10, 5'd11, 5'd12, 16'd0, 26'd0, 1'b1);
        @(negedge clk);
        checks++;
        if ({we0, addr0, wdata0} !== {1'b1, 6'd0, 32'h014B6025}) begin
            errors++;
            $display("FAIL midflight_reload: got we=%b addr=%0d data=%h want 1/0/014B6025", we0, addr0, wdata0);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [32:0] m;
        int op, nw, n;
        bit exp_err;
        do_reset();
        pulse_start();
        nw = 0; exp_err = 1'b0; n = 24;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            m = model_encode(op, int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm), int'(in_target));
            if (m[32]) begin
                exp_q.push_back({6'(nw), m[31:0]});
                nw++;
            end else begin
                exp_err = 1'b1;
            end
            send(1'b0, 4'(op), in_rs, in_rt, in_rd, in_imm, in_target, i == n - 1);
        end
        repeat (2) @(negedge clk);
        checks++; if (obs0_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_write_count: got %0d want %0d", obs0_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs0_q.size(); i++) begin
            checks++;
            if (obs0_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_write[%0d]: got %h want %h", i, obs0_q[i], exp_q[i]); end
        end
        checks++; if (count0 !== 7'(nw)) begin errors++; $display("FAIL rand_count: got %0d want %0d", count0, nw); end
        checks++; if (err0 !== exp_err) begin errors++; $display("FAIL rand_err_illegal: got %b want %b", err0, exp_err); end
        checks++; if (done0 !== 1'b1 || full0 !== 1'b0) begin errors++; $display("FAIL rand_done: got done=%b full=%b want 1/0", done0, full0); end
    endtask

    initial begin
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        test_reset();
        test_single_add();
        test_program();
        test_unused_fields();
        test_illegal();
        test_capacity();
        test_reset_midflight();
        test_back_to_back_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential instruction encoder and program loader for the pipelined MIPS core. It accepts symbolic instructions (operation code plus register, immediate and target fields) over a valid/ready handshake. It packs each one into a 32-bit MIPS word using the opcode/funct encodings the Decode-stage control unit decodes, and writes the words to consecutive instruction-memory locations from address 0. It sits between the testbench/boot host and instruction memory, and tells the core when the program image is complete.

## Interface
- ADDR_W, 6: instruction-memory word-address width; capacity is 2**ADDR_W words.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begins a new load; sampled only in IDLE or DONE.
- in_valid  input  1  source presents an instruction.
- in_ready  output  1  loader accepts an instruction this cycle.
- in_last  input  1  marks the final instruction of the program; qualified by the handshake.
- in_op  input  4  0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10-15 illegal.
- in_rs, in_rt, in_rd  input  5 each  register fields.
- in_imm  input  16  immediate for lw/sw/beq/addi.
- in_target  input  26  jump target for j.
- imem_we  output  1  instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  encoded instruction word.
- count  output  ADDR_W+1  number of words written in the current load.
- done  output  1  load complete; held until the next start.
- full  output  1  load ended because memory capacity was reached.
- err_illegal  output  1  sticky; set when an illegal in_op is received in the current load.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE -> ACCEPT on start. Entering ACCEPT clears the address pointer, count, full and err_illegal.
- ACCEPT: in_ready=1. A handshake (in_valid & in_ready) registers the encoded word and in_last, then moves to WRITE.
  - If in_op is illegal: no word is registered and err_illegal is set. If in_last is also set, go to DONE. Otherwise stay in ACCEPT.
- WRITE: imem_we=1 for exactly one cycle with imem_addr = pointer and imem_wdata = registered word. The pointer and count increment. Next state:
  - DONE if in_last was captured, or if the pointer was 2**ADDR_W-1. In the capacity case, full=1.
  - ACCEPT otherwise.
- DONE: done=1 and in_ready=0. start restarts the load from address 0, going to ACCEPT.
- start is ignored in ACCEPT and WRITE.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, 5'b0, funct}, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type: {opcode, rs, rt, imm}, with opcode lw 100011, sw 101011, beq 000100, addi 001000.
  - J-type: {000010, target}.
  - Fields not used by an operation are ignored and never leak into the word; for example, in_rd is ignored for I-types.

## Timing
- Reset values: state IDLE; in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, count 0, done 0, full 0, err_illegal 0.
- Reset is asynchronous: asserting it mid-load clears everything immediately and drops any in-flight word.
- All outputs are registered or decoded from the registered state; there is no combinational path from inputs to outputs.
- Latency: a handshake in cycle N gives imem_we=1 in cycle N+1. count reflects the write in cycle N+2.
- Throughput: at most one instruction per 2 cycles, because in_ready is low during WRITE.
- done rises in the cycle after the final WRITE, or in the cycle after an illegal handshake that carries in_last.
- Capacity: the word at address 2**ADDR_W-1 is written, and then DONE is entered with full=1 and count=2**ADDR_W. The pointer never wraps within a load.
- in_valid while in_ready=0 has no effect; the source must hold its data.

## Test plan
- Reset release, start, then add rs=1 rt=2 rd=3 -> imem_we at addr 0 with data 0x00221820; count=1.
- Program of lw rs=0 rt=8 imm=4, then sub rs=4 rt=5 rd=6, then j target=0x10 with in_last -> addr 0/1/2 receive 0x8C080004, 0x00853022, 0x08000010; done=1, count=3, full=0.
- beq rs=1 rt=2 imm=0xFFFF with in_rd=31 -> 0x1022FFFF (in_rd ignored).
- in_op=12 with in_valid held, followed by a legal add -> no write for op 12; err_illegal=1 and stays set; the add lands at addr 0.
- ADDR_W=2, six instructions offered without in_last -> exactly 4 writes (addr 0-3); done=1, full=1, count=4; in_ready stays 0 afterwards.
- reset asserted in the cycle right after a handshake -> no imem_we pulse and all outputs 0. A following start loads from addr 0 again.
